collision_detector_multi: RTL and testbench

- Sequential, parametrised successor to the single-ghost collision check.
- Compares the pacman position against NUM_GHOSTS ghosts once per frame, one ghost per clock, on map-tile indices with a configurable proximity tolerance.
- Distinguishes lethal hits from frightened-ghost hits, which are eaten.
- Sits between the position/movement logic and the game-state controller; started by the frame tick.

---
 rtl/collision_detector_multi_pkg.sv | 23 ++
 rtl/collision_detector_multi_tile.sv | 30 +++
 rtl/collision_detector_multi.sv | 170 +++++++++++++++++
 tb/tb_collision_detector_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/collision_detector_multi_pkg.sv
// Shared game constants for the collision detector: default coordinate and
// tile-index widths, tile size, map origin, and the scan FSM encoding.
package collision_detector_multi_pkg;

    localparam int DEF_POS_X_W   = 11;
    localparam int DEF_POS_Y_W   = 10;
    localparam int DEF_IDX_X_W   = 7;
    localparam int DEF_IDX_Y_W   = 6;
    localparam int DEF_TILE_LOG2 = 4;
    localparam int DEF_ORIGIN_X  = 0;
    localparam int DEF_ORIGIN_Y  = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SCAN   = ST_SCAN,
        REPORT = ST_REPORT
    } cd_state_e;

endpackage

// File: rtl/collision_detector_multi_tile.sv
// Display coordinate to map tile index. Positions left of/above the origin
// clamp to tile 0; indices past the map edge saturate to the last tile.
module pos_to_tile_index #(
    parameter int POS_W     = 11,
    parameter int IDX_W     = 7,
    parameter int TILE_LOG2 = 4,
    parameter int ORIGIN    = 0
) (
    input  logic [POS_W-1:0] pos,
    output logic [IDX_W-1:0] idx
);

    localparam logic [POS_W-1:0] ORG     = POS_W'(ORIGIN);
    localparam logic [31:0]      IDX_MAX = 32'((64'd1 << IDX_W) - 64'd1);

    logic             borrow;
    logic [POS_W-1:0] off;
    logic [31:0]      tile;

    // Subtract the origin, detect underflow via the borrow bit, then shift and saturate.
    always_comb begin
        {borrow, off} = {1'b0, pos} - {1'b0, ORG};
        tile          = 32'(off >> TILE_LOG2);
        idx           = '0;
        if (!borrow) begin
            idx = (tile > IDX_MAX) ? IDX_MAX[IDX_W-1:0] : tile[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/collision_detector_multi.sv
// Per-frame pacman/ghost collision scan. One ghost is checked per clock from
// a snapshot taken at the start edge; results are published on a done pulse
// and held until the next report.
module collision_detector_multi
    import collision_detector_multi_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int POS_X_W    = DEF_POS_X_W,
    parameter int POS_Y_W    = DEF_POS_Y_W,
    parameter int IDX_X_W    = DEF_IDX_X_W,
    parameter int IDX_Y_W    = DEF_IDX_Y_W,
    parameter int TILE_LOG2  = DEF_TILE_LOG2,
    parameter int ORIGIN_X   = DEF_ORIGIN_X,
    parameter int ORIGIN_Y   = DEF_ORIGIN_Y,
    parameter int TOL        = 0,
    localparam int CNT_W     = $clog2(NUM_GHOSTS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [POS_X_W-1:0]            pacman_pos_x,
    input  logic [POS_Y_W-1:0]            pacman_pos_y,
    input  logic [NUM_GHOSTS*POS_X_W-1:0] ghost_pos_x,
    input  logic [NUM_GHOSTS*POS_Y_W-1:0] ghost_pos_y,
    input  logic [NUM_GHOSTS-1:0]         ghost_active,
    input  logic [NUM_GHOSTS-1:0]         ghost_frightened,
    output logic                          busy,
    output logic                          done,
    output logic                          pacman_is_dead,
    output logic [NUM_GHOSTS-1:0]         ghost_eaten,
    output logic [CNT_W-1:0]              hit_count
);

    localparam int GI_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

    cd_state_e state_q, state_d;
    logic [GI_W-1:0]               idx_q, idx_d;
    logic [POS_X_W-1:0]            pac_x_q, pac_x_d;
    logic [POS_Y_W-1:0]            pac_y_q, pac_y_d;
    logic [NUM_GHOSTS*POS_X_W-1:0] gx_q, gx_d;
    logic [NUM_GHOSTS*POS_Y_W-1:0] gy_q, gy_d;
    logic [NUM_GHOSTS-1:0]         act_q, act_d;
    logic [NUM_GHOSTS-1:0]         fr_q, fr_d;
    logic                          dead_acc_q, dead_acc_d;
    logic [NUM_GHOSTS-1:0]         eaten_acc_q, eaten_acc_d;
    logic [CNT_W-1:0]              cnt_acc_q, cnt_acc_d;
    logic                          dead_q, dead_d;
    logic [NUM_GHOSTS-1:0]         eaten_q, eaten_d;
    logic [CNT_W-1:0]              hits_q, hits_d;

    logic [POS_X_W-1:0] cur_gx;
    logic [POS_Y_W-1:0] cur_gy;
    logic [IDX_X_W-1:0] pac_tx, gh_tx, dx;
    logic [IDX_Y_W-1:0] pac_ty, gh_ty, dy;
    logic               hit;

    assign cur_gx = gx_q[idx_q*POS_X_W +: POS_X_W];
    assign cur_gy = gy_q[idx_q*POS_Y_W +: POS_Y_W];

    pos_to_tile_index #(.POS_W(POS_X_W), .IDX_W(IDX_X_W), .TILE_LOG2(TILE_LOG2), .ORIGIN(ORIGIN_X))
        u_pac_tx (.pos(pac_x_q), .idx(pac_tx));
    pos_to_tile_index #(.POS_W(POS_Y_W), .IDX_W(IDX_Y_W), .TILE_LOG2(TILE_LOG2), .ORIGIN(ORIGIN_Y))
        u_pac_ty (.pos(pac_y_q), .idx(pac_ty));
    pos_to_tile_index #(.POS_W(POS_X_W), .IDX_W(IDX_X_W), .TILE_LOG2(TILE_LOG2), .ORIGIN(ORIGIN_X))
        u_gh_tx (.pos(cur_gx), .idx(gh_tx));
    pos_to_tile_index #(.POS_W(POS_Y_W), .IDX_W(IDX_Y_W), .TILE_LOG2(TILE_LOG2), .ORIGIN(ORIGIN_Y))
        u_gh_ty (.pos(cur_gy), .idx(gh_ty));

    // Chebyshev proximity test on unsigned tile indices, gated by the snapshot active bit.
    always_comb begin
        dx  = (pac_tx >= gh_tx) ? (pac_tx - gh_tx) : (gh_tx - pac_tx);
        dy  = (pac_ty >= gh_ty) ? (pac_ty - gh_ty) : (gh_ty - pac_ty);
        hit = act_q[idx_q] && (32'(dx) <= 32'(TOL)) && (32'(dy) <= 32'(TOL));
    end

    // Next-state: snapshot on start, accumulate one ghost per SCAN cycle, publish on REPORT entry.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pac_x_d     = pac_x_q;
        pac_y_d     = pac_y_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        act_d       = act_q;
        fr_d        = fr_q;
        dead_acc_d  = dead_acc_q;
        eaten_acc_d = eaten_acc_q;
        cnt_acc_d   = cnt_acc_q;
        dead_d      = dead_q;
        eaten_d     = eaten_q;
        hits_d      = hits_q;

        case (state_q)
            IDLE, REPORT: begin
                state_d = IDLE;
                if (start) begin
                    pac_x_d     = pacman_pos_x;
                    pac_y_d     = pacman_pos_y;
                    gx_d        = ghost_pos_x;
                    gy_d        = ghost_pos_y;
                    act_d       = ghost_active;
                    fr_d        = ghost_frightened;
                    dead_acc_d  = 1'b0;
                    eaten_acc_d = '0;
                    cnt_acc_d   = '0;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    cnt_acc_d = cnt_acc_q + CNT_W'(1);
                    if (fr_q[idx_q]) eaten_acc_d[idx_q] = 1'b1;
                    else             dead_acc_d         = 1'b1;
                end
                if (idx_q == GI_W'(NUM_GHOSTS - 1)) begin
                    dead_d  = dead_acc_d;
                    eaten_d = eaten_acc_d;
                    hits_d  = cnt_acc_d;
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + GI_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, snapshot, accumulator and result registers; reset aborts any scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pac_x_q     <= '0;
            pac_y_q     <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            act_q       <= '0;
            fr_q        <= '0;
            dead_acc_q  <= 1'b0;
            eaten_acc_q <= '0;
            cnt_acc_q   <= '0;
            dead_q      <= 1'b0;
            eaten_q     <= '0;
            hits_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pac_x_q     <= pac_x_d;
            pac_y_q     <= pac_y_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            act_q       <= act_d;
            fr_q        <= fr_d;
            dead_acc_q  <= dead_acc_d;
            eaten_acc_q <= eaten_acc_d;
            cnt_acc_q   <= cnt_acc_d;
            dead_q      <= dead_d;
            eaten_q     <= eaten_d;
            hits_q      <= hits_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == REPORT);
    assign pacman_is_dead = dead_q;
    assign ghost_eaten    = eaten_q;
    assign hit_count      = hits_q;

endmodule

// File: tb/tb_collision_detector_multi.sv
// Directed bench for collision_detector_multi. dut0 uses defaults (TOL=0,
// origin 0); dut1 uses TOL=1, origin (32,16) and a 6-bit column index so
// clamping and saturation are observable. Both share the same inputs.
module tb_collision_detector_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] pac_x = '0;
    logic [9:0]  pac_y = '0;
    logic [43:0] gpx = '0;
    logic [39:0] gpy = '0;
    logic [3:0]  act = '0;
    logic [3:0]  fr = '0;

    logic       busy0, done0, dead0, busy1, done1, dead1;
    logic [3:0] eaten0, eaten1;
    logic [2:0] cnt0, cnt1;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    collision_detector_multi u_dut0 (
        .clk(clk), .reset(reset), .start(start),
        .pacman_pos_x(pac_x), .pacman_pos_y(pac_y),
        .ghost_pos_x(gpx), .ghost_pos_y(gpy),
        .ghost_active(act), .ghost_frightened(fr),
        .busy(busy0), .done(done0), .pacman_is_dead(dead0),
        .ghost_eaten(eaten0), .hit_count(cnt0)
    );

    collision_detector_multi #(.IDX_X_W(6), .ORIGIN_X(32), .ORIGIN_Y(16), .TOL(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
        .pacman_pos_x(pac_x), .pacman_pos_y(pac_y),
        .ghost_pos_x(gpx), .ghost_pos_y(gpy),
        .ghost_active(act), .ghost_frightened(fr),
        .busy(busy1), .done(done1), .pacman_is_dead(dead1),
        .ghost_eaten(eaten1), .hit_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        gpx[i*11 +: 11] = 11'(x);
        gpy[i*10 +: 10] = 10'(y);
    endtask

    task automatic chk_res0(input string tag, input logic d, input logic [3:0] e, input logic [2:0] c);
        chk({tag, ".dead0"},  32'(dead0),  32'(d));
        chk({tag, ".eaten0"}, 32'(eaten0), 32'(e));
        chk({tag, ".cnt0"},   32'(cnt0),   32'(c));
    endtask

    task automatic chk_res1(input string tag, input logic d, input logic [3:0] e, input logic [2:0] c);
        chk({tag, ".dead1"},  32'(dead1),  32'(d));
        chk({tag, ".eaten1"}, 32'(eaten1), 32'(e));
        chk({tag, ".cnt1"},   32'(cnt1),   32'(c));
    endtask

    // Pulse start for one cycle, then watch 10 cycles; done must appear once,
    // in the cycle after the 4th edge following the start edge (k==4).
    task automatic do_scan(input string tag);
        int n0, n1, p0, p1;
        n0 = 0; n1 = 0; p0 = -1; p1 = -1;
        @(negedge clk) start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (done0) begin n0++; if (p0 < 0) p0 = k; end
            if (done1) begin n1++; if (p1 < 0) p1 = k; end
        end
        chk({tag, ".ndone0"}, 32'(n0), 32'd1);
        chk({tag, ".pdone0"}, 32'(p0), 32'd4);
        chk({tag, ".ndone1"}, 32'(n1), 32'd1);
        chk({tag, ".pdone1"}, 32'(p1), 32'd4);
    endtask

    initial begin
        int nd, pd;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy0", 32'(busy0), 32'd0);
        chk("rst.done0", 32'(done0), 32'd0);
        chk_res0("rst", 1'b0, 4'b0000, 3'd0);
        chk("rst.busy1", 32'(busy1), 32'd0);
        reset = 1'b0;

        // Exact overlap, lethal ghost2 on dut0 (tile (10,6) for both)
        pac_x = 11'd160; pac_y = 10'd96;
        set_ghost(0, 400, 300); set_ghost(1, 600, 200);
        set_ghost(2, 165, 100); set_ghost(3, 800, 400);
        act = 4'b1111; fr = 4'b0000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("lat.busy_after_start", 32'(busy0), 32'd1);
        chk("lat.done_after_start", 32'(done0), 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("lat.no_early_done", 32'(done0), 32'd0);
        end
        @(negedge clk);
        chk("lat.done", 32'(done0), 32'd1);
        chk_res0("exact", 1'b1, 4'b0000, 3'd1);
        @(negedge clk);
        chk("lat.done_one_cycle", 32'(done0), 32'd0);
        chk("lat.busy_clear", 32'(busy0), 32'd0);
        chk_res0("hold", 1'b1, 4'b0000, 3'd1);

        // Frightened eat
        fr = 4'b0100;
        do_scan("fright");
        chk_res0("fright", 1'b0, 4'b0100, 3'd1);

        // Mixed hits with TOL=1 on dut1: pacman tile (10,6)
        pac_x = 11'd192; pac_y = 10'd112;
        set_ghost(0, 208, 128);   // tile (11,7) lethal
        set_ghost(1, 224, 112);   // tile (12,6) out of tolerance
        set_ghost(2, 1000, 500);
        set_ghost(3, 176, 112);   // tile (9,6) frightened
        act = 4'b1011; fr = 4'b1000;
        do_scan("mixed");
        chk_res1("mixed", 1'b1, 4'b1000, 3'd2);

        // Snapshot: change inputs and re-pulse start mid-scan (dut0)
        pac_x = 11'd160; pac_y = 10'd96;
        set_ghost(0, 400, 300); set_ghost(1, 600, 200);
        set_ghost(2, 165, 100); set_ghost(3, 800, 400);
        act = 4'b1111; fr = 4'b0000;
        nd = 0; pd = -1;
        @(negedge clk) start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                set_ghost(2, 900, 400);
                set_ghost(0, 160, 96);
                fr = 4'b0001;
            end
            if (k == 1) start = 1'b1;
            if (k == 2) start = 1'b0;
            if (done0) begin nd++; if (pd < 0) pd = k; end
        end
        chk("snap.ndone", 32'(nd), 32'd1);
        chk("snap.pdone", 32'(pd), 32'd4);
        chk_res0("snap", 1'b1, 4'b0000, 3'd1);

        // Inactive ghosts on pacman's tile never hit
        pac_x = 11'd192; pac_y = 10'd112;
        for (int i = 0; i < 4; i++) set_ghost(i, 192, 112);
        act = 4'b0000; fr = 4'b0000;
        do_scan("inact");
        chk_res0("inact", 1'b0, 4'b0000, 3'd0);
        chk_res1("inact", 1'b0, 4'b0000, 3'd0);

        // Clamp on dut1: pacman x < origin -> col 0, ghost0 x=40 -> col 0
        pac_x = 11'd10; pac_y = 10'd112;
        set_ghost(0, 40, 112); set_ghost(1, 2047, 112);
        act = 4'b0011; fr = 4'b0010;
        do_scan("clamp");
        chk_res1("clamp", 1'b1, 4'b0000, 3'd1);

        // Saturation on dut1: x=1500 and x=2047 both saturate to col 63
        pac_x = 11'd1500;
        do_scan("sat");
        chk_res1("sat", 1'b0, 4'b0010, 3'd1);

        // Reset two cycles after start
        pac_x = 11'd160; pac_y = 10'd96;
        set_ghost(0, 400, 300); set_ghost(1, 600, 200);
        set_ghost(2, 165, 100); set_ghost(3, 800, 400);
        act = 4'b1111; fr = 4'b0000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmid.busy0", 32'(busy0), 32'd0);
        chk("rmid.busy1", 32'(busy1), 32'd0);
        chk("rmid.done0", 32'(done0), 32'd0);
        chk_res0("rmid", 1'b0, 4'b0000, 3'd0);
        chk_res1("rmid", 1'b0, 4'b0000, 3'd0);
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done0 || done1) nd++;
        end
        chk("rmid.no_done", 32'(nd), 32'd0);
        do_scan("fresh");
        chk_res0("fresh", 1'b1, 4'b0000, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
